// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller.
//  - Tuse/Tnew encodings (cycles until an operand is needed / a result is
//    forwardable). TUSE_NEVER marks an operand the instruction never reads.
//  - Mult/div sequencer state enum.
//  - raw_hit(): one operand-vs-producer RAW comparison.
package hazard_stall_ctrl_pkg;

  localparam logic [1:0] TUSE_0     = 2'd0;
  localparam logic [1:0] TUSE_1     = 2'd1;
  localparam logic [1:0] TUSE_2     = 2'd2;
  localparam logic [1:0] TUSE_NEVER = 2'd3;

  localparam logic [1:0] TNEW_0 = 2'd0;
  localparam logic [1:0] TNEW_1 = 2'd1;
  localparam logic [1:0] TNEW_2 = 2'd2;
  localparam logic [1:0] TNEW_3 = 2'd3;

  typedef enum logic {MD_IDLE, MD_BUSY} md_state_e;

  // A source register collides with a producer when it names the same
  // non-zero register and is needed before the producer can forward it.
  // $0 is hard-wired, so writes to it never create a hazard.
  function automatic logic raw_hit(input logic [4:0] src, input logic [1:0] tuse,
                                   input logic [4:0] dst, input logic [1:0] tnew);
    return (src != 5'd0) && (src == dst) && (tuse < tnew);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_md_sequencer.sv
// Mult/div sequencer: two-state FSM plus busy countdown.
// Ports:
//  clk, reset     clock, synchronous active-high reset
//  i_md_start_E   E-stage instruction is mult/multu/div/divu
//  i_md_div_E     1 = div type, 0 = mult type
//  o_md_start     one-cycle start pulse to the mult/div datapath
//  o_md_busy      unit occupied (BUSY state, or a start being issued now)
//  o_hilo_we      one-cycle HI/LO write strobe on completion
module hazard_stall_ctrl_md_sequencer
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_md_start_E,
  input  logic i_md_div_E,
  output logic o_md_start,
  output logic o_md_busy,
  output logic o_hilo_we
);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= MD_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Start cycle is cycle 0 and loads LAT-1; the strobe fires when the count
  // reaches 1, i.e. in cycle LAT-1. A start seen while BUSY is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_md_start  = 1'b0;
    o_hilo_we   = 1'b0;
    case (r_state)
      MD_IDLE: begin
        if (i_md_start_E) begin
          o_md_start  = 1'b1;
          w_cnt_nxt   = i_md_div_E ? DIV_LOAD : MULT_LOAD;
          w_state_nxt = MD_BUSY;
        end
      end
      MD_BUSY: begin
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          o_hilo_we   = 1'b1;
          w_state_nxt = MD_IDLE;
        end
      end
      default: begin
        w_state_nxt = MD_IDLE;
      end
    endcase
    // A reset cycle abandons any operation: no start, no HI/LO write.
    if (reset) begin
      o_md_start = 1'b0;
      o_hilo_we  = 1'b0;
    end
  end

  assign o_md_busy = (r_state == MD_BUSY) | i_md_start_E;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
//  Detects RAW hazards between the D-stage instruction and E/M producers
//  using Tuse/Tnew, holds HI/LO users in D while mult/div is busy, and counts
//  stall cycles (saturating) for performance debug.
// Ports:
//  clk, reset                 clock, synchronous active-high reset
//  rs_D, rt_D                 D-stage source registers
//  tuse_rs_D, tuse_rt_D       cycles until D needs rs/rt (3 = never)
//  A3_E, tnew_E               E-stage destination (0 = none) and Tnew
//  A3_M, tnew_M               M-stage destination (0 = none) and Tnew
//  md_start_E, md_div_E       E-stage mult/div launch and type
//  md_use_D                   D-stage instruction touches mult/div or HI/LO
//  PC_en, D_en, E_clr         PC enable, D register enable, E bubble insert
//  md_start, md_busy, hilo_we mult/div sequencing outputs
//  stall_cnt                  saturating stall-cycle count
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  tuse_rs_D,
  input  logic [1:0]  tuse_rt_D,
  input  logic [4:0]  A3_E,
  input  logic [1:0]  tnew_E,
  input  logic [4:0]  A3_M,
  input  logic [1:0]  tnew_M,
  input  logic        md_start_E,
  input  logic        md_div_E,
  input  logic        md_use_D,
  output logic        PC_en,
  output logic        D_en,
  output logic        E_clr,
  output logic        md_start,
  output logic        md_busy,
  output logic        hilo_we,
  output logic [31:0] stall_cnt
);

  logic        w_stall_rs;
  logic        w_stall_rt;
  logic        w_stall_md;
  logic        w_stall;
  logic        w_md_busy;
  logic [31:0] r_stall_cnt;

  hazard_stall_ctrl_md_sequencer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_seq (
    .clk          (clk),
    .reset        (reset),
    .i_md_start_E (md_start_E),
    .i_md_div_E   (md_div_E),
    .o_md_start   (md_start),
    .o_md_busy    (w_md_busy),
    .o_hilo_we    (hilo_we)
  );

  assign w_stall_rs = raw_hit(rs_D, tuse_rs_D, A3_E, tnew_E) |
                      raw_hit(rs_D, tuse_rs_D, A3_M, tnew_M);
  assign w_stall_rt = raw_hit(rt_D, tuse_rt_D, A3_E, tnew_E) |
                      raw_hit(rt_D, tuse_rt_D, A3_M, tnew_M);
  assign w_stall_md = md_use_D & w_md_busy;
  // One stall flag, so overlapping causes are counted once per cycle.
  assign w_stall    = w_stall_rs | w_stall_rt | w_stall_md;

  assign PC_en   = ~w_stall;
  assign D_en    = ~w_stall;
  assign E_clr   = w_stall;
  assign md_busy = w_md_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CNT_W    = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs_D, rt_D, A3_E, A3_M;
  logic [1:0]  tuse_rs_D, tuse_rt_D, tnew_E, tnew_M;
  logic        md_start_E, md_div_E, md_use_D;
  logic        PC_en, D_en, E_clr, md_start, md_busy, hilo_we;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  hazard_stall_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .tuse_rs_D(tuse_rs_D), .tuse_rt_D(tuse_rt_D),
    .A3_E(A3_E), .tnew_E(tnew_E), .A3_M(A3_M), .tnew_M(tnew_M),
    .md_start_E(md_start_E), .md_div_E(md_div_E), .md_use_D(md_use_D),
    .PC_en(PC_en), .D_en(D_en), .E_clr(E_clr),
    .md_start(md_start), .md_busy(md_busy), .hilo_we(hilo_we),
    .stall_cnt(stall_cnt)
  );

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt, a3e, a3m;
    logic [1:0] urs, urt, ne, nm;
    logic       mse, mdiv, muse;
  } stim_t;

  typedef struct packed {
    int          cyc;
    logic        pc_en, d_en, e_clr, md_start, md_busy, hilo_we;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state: whether an operation is in flight (after its start
  // cycle) and the absolute cycle in which it completes.
  int          cyc    = 0;
  bit          m_busy = 0;
  int          m_end  = 0;
  logic [31:0] m_cnt  = 0;

  function automatic bit hazard(input int src, input int need, input int dst, input int ready);
    return (src != 0) && (src == dst) && (need < ready);
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   stall;
    @(posedge clk);
    #1;
    reset = s.rst; rs_D = s.rs; rt_D = s.rt; tuse_rs_D = s.urs; tuse_rt_D = s.urt;
    A3_E = s.a3e; tnew_E = s.ne; A3_M = s.a3m; tnew_M = s.nm;
    md_start_E = s.mse; md_div_E = s.mdiv; md_use_D = s.muse;

    e.cyc      = cyc;
    e.md_busy  = m_busy || s.mse;
    e.md_start = !m_busy && s.mse && !s.rst;
    e.hilo_we  = m_busy && (cyc == m_end) && !s.rst;
    stall = hazard(int'(s.rs), int'(s.urs), int'(s.a3e), int'(s.ne)) ||
            hazard(int'(s.rs), int'(s.urs), int'(s.a3m), int'(s.nm)) ||
            hazard(int'(s.rt), int'(s.urt), int'(s.a3e), int'(s.ne)) ||
            hazard(int'(s.rt), int'(s.urt), int'(s.a3m), int'(s.nm)) ||
            (s.muse && e.md_busy);
    e.pc_en = !stall;
    e.d_en  = !stall;
    e.e_clr = stall;
    e.cnt   = m_cnt;
    q.push_back(e);

    if (s.rst) begin
      m_busy = 0;
      m_cnt  = 0;
    end else begin
      if (e.md_start) begin
        m_busy = 1;
        m_end  = cyc + (s.mdiv ? DIV_LAT : MULT_LAT) - 1;
      end else if (m_busy && cyc == m_end) begin
        m_busy = 0;
      end
      if (stall && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    end
    cyc++;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.urs = 2'd3;
    s.urt = 2'd3;
    return s;
  endfunction

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, c, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents a full output set; compare it
  // against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PC_en",     e.cyc, 32'(PC_en),    32'(e.pc_en));
        chk("D_en",      e.cyc, 32'(D_en),     32'(e.d_en));
        chk("E_clr",     e.cyc, 32'(E_clr),    32'(e.e_clr));
        chk("md_start",  e.cyc, 32'(md_start), 32'(e.md_start));
        chk("md_busy",   e.cyc, 32'(md_busy),  32'(e.md_busy));
        chk("hilo_we",   e.cyc, 32'(hilo_we),  32'(e.hilo_we));
        chk("stall_cnt", e.cyc, stall_cnt,     e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    rs_D = '0; rt_D = '0; tuse_rs_D = 2'd3; tuse_rt_D = 2'd3;
    A3_E = '0; tnew_E = '0; A3_M = '0; tnew_M = '0;
    md_start_E = 1'b0; md_div_E = 1'b0; md_use_D = 1'b0;

    // Reset state.
    s = idle(); s.rst = 1'b1;
    apply(s); apply(s);
    s = idle(); apply(s);

    // RAW on E producer: stall.
    s = idle(); s.a3e = 5'd8; s.ne = 2'd2; s.rs = 5'd8; s.urs = 2'd0; apply(s);
    // $0 never hazards.
    s = idle(); s.a3e = 5'd0; s.ne = 2'd2; s.rs = 5'd0; s.urs = 2'd0; apply(s);
    // Forwardable M result: no stall.
    s = idle(); s.a3m = 5'd9; s.nm = 2'd1; s.rt = 5'd9; s.urt = 2'd1; apply(s);
    apply(idle());

    // Mult launch, then idle until well after completion.
    s = idle(); s.mse = 1'b1; s.mdiv = 1'b0; apply(s);
    for (int i = 0; i < 6; i++) apply(idle());

    // Div launch with a HI/LO user waiting in D from cycle 1.
    s = idle(); s.mse = 1'b1; s.mdiv = 1'b1; apply(s);
    for (int i = 0; i < 10; i++) begin
      s = idle(); s.muse = 1'b1; apply(s);
    end
    apply(idle());

    // Div abandoned by reset in its cycle 3.
    s = idle(); s.mse = 1'b1; s.mdiv = 1'b1; apply(s);
    s = idle(); s.muse = 1'b1; apply(s); apply(s);
    s = idle(); s.rst = 1'b1; s.muse = 1'b1; apply(s);
    for (int i = 0; i < 12; i++) apply(idle());

    // Random traffic; small register range to provoke collisions.
    for (int i = 0; i < 2000; i++) begin
      s.rst  = ($urandom_range(0, 99) == 0);
      s.rs   = 5'($urandom_range(0, 3));
      s.rt   = 5'($urandom_range(0, 3));
      s.a3e  = 5'($urandom_range(0, 3));
      s.a3m  = 5'($urandom_range(0, 3));
      s.urs  = 2'($urandom_range(0, 3));
      s.urt  = 2'($urandom_range(0, 3));
      s.ne   = 2'($urandom_range(0, 3));
      s.nm   = 2'($urandom_range(0, 3));
      s.mse  = ($urandom_range(0, 5) == 0);
      s.mdiv = 1'($urandom_range(0, 1));
      s.muse = ($urandom_range(0, 2) == 0);
      apply(s);
    end

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
